// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment refresh scheduler and its BCD engine.
package seg7_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {R0, R1, R2} range_e;

  typedef enum logic [1:0] {StIdle, StShift, StRange, StCommit} state_e;

  localparam int unsigned TH1      = 10_000;
  localparam int unsigned TH2      = 100_000;
  localparam int unsigned SAT      = 999_999;
  localparam int unsigned NDIG_BCD = 7;
  localparam int unsigned NBIN     = 20;

  function automatic logic [2:0] range_onehot(range_e r);
    logic [2:0] led;
    led = 3'b000;
    case (r)
      R0:      led = 3'b001;
      R1:      led = 3'b010;
      R2:      led = 3'b100;
      default: led = 3'b000;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/bcd_dd_serial.sv
// Serial double-dabble binary-to-BCD converter: one shift per cycle, NBIN cycles after start.
module bcd_dd_serial #(
  parameter int unsigned NBIN     = 20,
  parameter int unsigned NDIG_BCD = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [NBIN-1:0]         bin,
  output logic                    done,
  output logic [4*NDIG_BCD-1:0]   bcd
);

  localparam int unsigned CW = $clog2(NBIN);
  localparam logic [CW-1:0] CNT_LAST = CW'(NBIN - 1);

  logic [NBIN-1:0]       bin_q, bin_d;
  logic [4*NDIG_BCD-1:0] bcd_q, bcd_d, adj;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  run_q, run_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < int'(NDIG_BCD); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start) begin
      bin_d = bin;
      bcd_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      {bcd_d, bin_d} = {adj[4*NDIG_BCD-2:0], bin_q, 1'b0};
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  // High during the cycle whose closing edge performs the final shift.
  assign done = run_q && (cnt_q == CNT_LAST);
  assign bcd  = bcd_q;

endmodule

// File: rtl/seg7_refresh_scheduler.sv
// Periodic capture, BCD conversion, hysteretic range selection and atomic commit of
// four display digits plus range LEDs.
module seg7_refresh_scheduler
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_MS = 200,
  parameter int unsigned HYST       = 500
) (
  input  logic        clk,
  input  logic        KEY2,
  input  logic        time_1ms,
  input  logic [19:0] t,
  input  logic        hold,
  output logic [15:0] digit_out,
  output logic [2:0]  range_led,
  output logic        upd,
  output logic        busy,
  output logic        overflow,
  output logic        overrun
);

  localparam logic [9:0] MS_MAX = 10'(REFRESH_MS - 1);

  state_e state_q, state_d;
  range_e range_q, range_d;

  logic [9:0]  ms_cnt_q;
  logic        pend_q, overrun_q;
  logic [19:0] v_q;
  logic [31:0] v_ext;
  logic        req, start, dd_done;
  logic [4*NDIG_BCD-1:0] dd_bcd;
  bcd_t        digs [NDIG_BCD];

  logic [15:0] digit_q, digit_d;
  logic [2:0]  led_q, led_d;
  logic        upd_q, upd_d, ovf_q, ovf_d;

  assign req   = time_1ms && (ms_cnt_q == MS_MAX);
  assign start = (state_q == StIdle) && (req || pend_q) && !hold;
  assign v_ext = {12'd0, v_q};

  bcd_dd_serial #(
    .NBIN     (NBIN),
    .NDIG_BCD (NDIG_BCD)
  ) u_dd (
    .clk   (clk),
    .rst_n (KEY2),
    .start (start),
    .bin   (t),
    .done  (dd_done),
    .bcd   (dd_bcd)
  );

  always_ff @(posedge clk or negedge KEY2) begin
    if (!KEY2) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start) state_d = StShift;
      StShift:  if (dd_done) state_d = StRange;
      StRange:  state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    range_d = range_q;
    if (state_q == StRange) begin
      case (range_q)
        R0: begin
          if (v_ext >= TH2)      range_d = R2;
          else if (v_ext >= TH1) range_d = R1;
        end
        R1: begin
          if (v_ext >= TH2)             range_d = R2;
          else if (v_ext < TH1 - HYST)  range_d = R0;
        end
        R2: begin
          if (v_ext < TH1 - HYST)       range_d = R0;
          else if (v_ext < TH2 - HYST)  range_d = R1;
        end
        default: range_d = R0;
      endcase
      if (v_ext > SAT) range_d = R2;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NDIG_BCD); i++) digs[i] = dd_bcd[4*i +: 4];
  end

  // Output comb: commit registers load only in COMMIT, so the display is never torn.
  always_comb begin
    digit_d = digit_q;
    led_d   = led_q;
    ovf_d   = ovf_q;
    upd_d   = 1'b0;
    if (state_q == StCommit) begin
      upd_d = 1'b1;
      led_d = range_onehot(range_q);
      // A nonzero seventh digit means the value is at least 1_000_000.
      ovf_d = (digs[6] != 4'd0);
      if (ovf_d) begin
        digit_d = 16'h9999;
      end else begin
        for (int k = 0; k < 4; k++) begin
          case (range_q)
            R0:      digit_d[4*k +: 4] = digs[k];
            R1:      digit_d[4*k +: 4] = digs[k+1];
            R2:      digit_d[4*k +: 4] = digs[k+2];
            default: digit_d[4*k +: 4] = 4'd0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge KEY2) begin
    if (!KEY2) begin
      ms_cnt_q  <= '0;
      pend_q    <= 1'b0;
      overrun_q <= 1'b0;
      v_q       <= '0;
      range_q   <= R0;
      digit_q   <= '0;
      led_q     <= '0;
      upd_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (time_1ms) ms_cnt_q <= (ms_cnt_q == MS_MAX) ? 10'd0 : ms_cnt_q + 10'd1;
      if (start) begin
        v_q    <= t;
        pend_q <= pend_q && req;
      end else if (state_q != StIdle && req) begin
        if (pend_q) overrun_q <= 1'b1;
        else        pend_q    <= 1'b1;
      end
      range_q <= range_d;
      digit_q <= digit_d;
      led_q   <= led_d;
      upd_q   <= upd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign digit_out = digit_q;
  assign range_led = led_q;
  assign upd       = upd_q;
  assign overflow  = ovf_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_seg7_refresh_scheduler.sv
// Directed and randomized bench for seg7_refresh_scheduler against a decimal-arithmetic model.
module tb_seg7_refresh_scheduler;

  localparam int HYST_TB = 500;

  logic        clk = 1'b0;
  logic        KEY2;
  logic        time_1ms;
  logic [19:0] t;
  logic        hold;
  logic [15:0] digit_out;
  logic [2:0]  range_led;
  logic        upd, busy, overflow, overrun;

  int total = 0;
  int bad   = 0;
  int model_range = 0;

  always #5 clk = ~clk;

  seg7_refresh_scheduler #(
    .REFRESH_MS (2),
    .HYST       (HYST_TB)
  ) dut (
    .clk       (clk),
    .KEY2      (KEY2),
    .time_1ms  (time_1ms),
    .t         (t),
    .hold      (hold),
    .digit_out (digit_out),
    .range_led (range_led),
    .upd       (upd),
    .busy      (busy),
    .overflow  (overflow),
    .overrun   (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_next(input int cur, input int v);
    if (v > 999_999) return 2;
    case (cur)
      0:       return (v >= 100_000) ? 2 : (v >= 10_000) ? 1 : 0;
      1:       return (v >= 100_000) ? 2 : (v < 10_000 - HYST_TB) ? 0 : 1;
      default: return (v < 10_000 - HYST_TB) ? 0 : (v < 100_000 - HYST_TB) ? 1 : 2;
    endcase
  endfunction

  function automatic logic [15:0] model_digits(input int v, input int r);
    int n;
    logic [15:0] d;
    if (v > 999_999) return 16'h9999;
    n = v;
    for (int i = 0; i < r; i++) n = n / 10;
    n = n % 10_000;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      d[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two ms pulses (REFRESH_MS=2) raise one request; the second edge is E0.
  task automatic do_request(input int v, input string tag);
    int n;
    logic [15:0] exp_d;
    t = 20'(v);
    time_1ms = 1'b1;
    tick();
    tick();
    time_1ms = 1'b0;
    t = 20'(v) ^ 20'h5A5A5;
    check({tag, "_busy_e0"}, 32'(busy), 32'd1);
    n = 0;
    while (n < 40 && !upd) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 22);
    model_range = model_next(model_range, v);
    exp_d = model_digits(v, model_range);
    check({tag, "_digits"}, 32'(digit_out), 32'(exp_d));
    check({tag, "_led"}, 32'(range_led), 32'(1 << model_range));
    check({tag, "_ovf"}, 32'(overflow), (v > 999_999) ? 32'd1 : 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    tick();
    check({tag, "_upd_pulse"}, 32'(upd), 32'd0);
  endtask

  initial begin
    int cnt;
    int v;
    logic [15:0] frozen;

    KEY2 = 1'b0; time_1ms = 1'b0; t = '0; hold = 1'b0;
    repeat (3) tick();
    check("rst_digits", 32'(digit_out), 32'd0);
    check("rst_led", 32'(range_led), 32'd0);
    check("rst_upd", 32'(upd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    KEY2 = 1'b1;
    tick();

    do_request(12345, "v12345");
    check("ex_12345", 32'(digit_out), 32'h1234);
    do_request(9600, "v9600");
    check("ex_9600_led", 32'(range_led), 32'b010);
    do_request(9400, "v9400");
    check("ex_9400", 32'(digit_out), 32'h9400);
    do_request(1_048_575, "vmax");
    check("ex_max", 32'(digit_out), 32'h9999);
    do_request(5, "v5");
    check("ex_5", 32'(digit_out), 32'h0005);

    // Hold across three refresh periods: nothing commits.
    frozen = digit_out;
    hold = 1'b1;
    time_1ms = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (upd) cnt++;
    end
    time_1ms = 1'b0;
    repeat (30) begin
      tick();
      if (upd) cnt++;
    end
    check("hold_no_upd", cnt, 0);
    check("hold_frozen", 32'(digit_out), 32'(frozen));
    check("hold_idle", 32'(busy), 32'd0);
    hold = 1'b0;
    do_request(54321, "after_hold");

    // Five requests back to back: one runs, one pends, later ones overrun.
    v = 77777;
    t = 20'(v);
    time_1ms = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (upd) cnt++;
    end
    time_1ms = 1'b0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (upd) cnt++;
    end
    model_range = model_next(model_range, v);
    model_range = model_next(model_range, v);
    check("ovr_commits", cnt, 2);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_digits", 32'(digit_out), 32'(model_digits(v, model_range)));
    do_request(321, "after_ovr");
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Reset ten cycles into a conversion.
    t = 20'd888_888;
    time_1ms = 1'b1;
    tick();
    tick();
    time_1ms = 1'b0;
    repeat (10) tick();
    KEY2 = 1'b0;
    #1;
    check("mid_rst_digits", 32'(digit_out), 32'd0);
    check("mid_rst_led", 32'(range_led), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_overrun", 32'(overrun), 32'd0);
    check("mid_rst_upd", 32'(upd), 32'd0);
    tick();
    KEY2 = 1'b1;
    model_range = 0;
    cnt = 0;
    repeat (30) begin
      tick();
      if (upd) cnt++;
    end
    check("mid_rst_no_upd", cnt, 0);
    do_request(4321, "after_rst");

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0:       v = int'($urandom_range(0, 20_000));
        1:       v = int'($urandom_range(5_000, 150_000));
        2:       v = int'($urandom_range(0, 999_999));
        default: v = int'($urandom_range(0, 1_048_575));
      endcase
      do_request(v, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
